mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one backing-memory port between the instruction cache (port 0) and data cache (port 1). It sits between the `o_mem_*`/`i_mem_*` interfaces of the two cache instances and the single memory. Each cache moves whole lines as bursts of 2^OFFSET_ADDR_W single-word beats, and the arbiter locks the grant for a full line so bursts never interleave. Default arbitration is round-robin; fixed data-cache priority is a compile option.

## Interface
- TOTAL_ADDR_W, 18, byte-address width; same value as the caches.
- OFFSET_ADDR_W, 4, log2 beats per line; burst length BURST_LEN = 2^OFFSET_ADDR_W.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_p0_ADDR, i_p1_ADDR  in  TOTAL_ADDR_W  requester beat address.
- i_p0_WDATA, i_p1_WDATA  in  32  requester write data.
- i_p0_BMASK, i_p1_BMASK  in  4  requester byte mask.
- i_p0_WREN, i_p1_WREN  in  1  1 = write beat, 0 = read beat.
- i_p0_VALID, i_p1_VALID  in  1  requester beat valid; held until READY.
- o_p0_READY, o_p1_READY  out  1  beat accepted by memory.
- o_p0_RDATA, o_p1_RDATA  out  32  read data; both ports are driven from i_mem_RDATA.
- o_mem_ADDR  out  TOTAL_ADDR_W; o_mem_WDATA  out  32; o_mem_BMASK  out  4; o_mem_WREN  out  1; o_mem_VALID  out  1.
- i_mem_RDATA  in  32; i_mem_READY  in  1.
- o_grant  out  2  one-hot current owner: bit0 = port 0, bit1 = port 1, 00 = none.

## Operation
- States:
  - ARB_IDLE: no owner.
  - ARB_P0: port 0 owns the memory.
  - ARB_P1: port 1 owns the memory.
- Beat counter `beat_cnt`, OFFSET_ADDR_W bits. Round-robin pointer `last`, 1 bit = last port granted.
- ARB_IDLE:
  - Only one VALID high: go to that port's state.
  - Both high: grant the port != `last`.
  - Neither high: stay.
  - `beat_cnt` is cleared on entry to ARB_P0/ARB_P1.
- ARB_Pn:
  - All o_mem_* outputs are muxed from port n.
  - o_pn_READY = i_mem_READY & i_pn_VALID.
  - The other port's READY is 0.
- Beat handshake = o_mem_VALID & i_mem_READY. Each handshake increments `beat_cnt`; it wraps naturally at BURST_LEN.
- Release:
  - The handshake with `beat_cnt == BURST_LEN-1` sets `last <= n` and goes to ARB_IDLE.
  - If the owner drops VALID mid-burst, the grant is held, o_mem_VALID = 0, and the count is frozen.
- A write-back followed by a fetch counts as two separate bursts. The arbiter re-arbitrates between them, so the other port may win in between.
- In ARB_IDLE all o_mem_* outputs and both READYs are 0.
- o_pn_RDATA = i_mem_RDATA unconditionally. It is meaningful only when o_pn_READY = 1.

## Timing
- Reset values: state ARB_IDLE, `beat_cnt` 0, `last` 1 (port 0 wins the first tie), o_grant 00.
- During reset all outputs are 0: o_mem_VALID, o_mem_WREN, o_mem_ADDR, o_mem_WDATA, o_mem_BMASK, o_p0_READY, o_p1_READY.
- Arbitration latency is 1 cycle. A request seen in ARB_IDLE at edge k is presented on o_mem_VALID in cycle k+1.
- Downstream paths are combinational while granted: VALID, ADDR, WDATA, BMASK, WREN and READY have no added register stage. A zero-wait memory therefore gives one beat per cycle.
- Burst of BURST_LEN beats with zero-wait memory: grant held BURST_LEN cycles, then 1 ARB_IDLE cycle, so BURST_LEN+1 cycles per line.
- A new request arriving during a burst is never serviced before the current burst releases.
- If the releasing port still has VALID high in ARB_IDLE and the other port is also requesting, the other port wins (round-robin).
- Asynchronous reset mid-burst:
  - immediate return to ARB_IDLE;
  - outputs go to reset values in the same cycle;
  - the partial burst is abandoned, and the requester is expected to be reset too.

## Configuration
- MEM_ARB_DCACHE_PRIO_EN defined:
  - on a tie in ARB_IDLE, port 1 (data cache) always wins;
  - `last` is not used;
  - burst locking is unchanged, so port 1 cannot preempt an active port-0 burst.
- Undefined: round-robin as described above.

## Test plan
- Single requester: p0 VALID held, memory READY always 1, BURST_LEN = 16.
  - o_grant = 01 from cycle 1.
  - 16 consecutive o_p0_READY pulses.
  - ARB_IDLE on cycle 17.
  - o_mem_ADDR tracks i_p0_ADDR.
- Tie after reset: p0 and p1 VALID asserted together.
  - p0 is served first.
  - p1 is granted in the cycle after p0's 16th beat plus the ARB_IDLE cycle.
  - With MEM_ARB_DCACHE_PRIO_EN, p1 is served first.
- Lock: p1 asserts VALID at p0 beat 5.
  - o_p1_READY stays 0 until p0 completes 16 beats.
  - No p1 address appears on o_mem_ADDR meanwhile.
- Wait states: i_mem_READY toggles 1,0,1,0.
  - Burst completes after exactly 16 handshakes (32 cycles).
  - WDATA and WREN (1 for write-back) are passed unchanged.
- Owner gap: p0 drops VALID for 3 cycles at beat 8.
  - o_mem_VALID = 0 during the gap; grant kept.
  - `beat_cnt` resumes at 8 and the burst still ends at beat 16.
- Reset mid-burst: assert i_rst at p1 beat 10.
  - o_mem_VALID and o_grant are 0 asynchronously.
  - After release, a p0-only request is granted 1 cycle later.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one backing-memory port between the instruction cache (port 0) and
// the data cache (port 1). Ownership is granted for a whole cache line
// (2^OFFSET_ADDR_W beats), so bursts from the two caches never interleave.
// Default arbitration on a tie is round-robin.
//
// Compile option:
//   MEM_ARB_DCACHE_PRIO_EN  defined   -> port 1 always wins a tie in ARB_IDLE
//                           undefined -> round-robin using last-granted port
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_pN_ADDR/WDATA/BMASK/WREN    requester beat (N = 0 icache, 1 dcache)
//   i_pN_VALID / o_pN_READY       requester beat handshake
//   o_pN_RDATA                    read data, straight from i_mem_RDATA
//   o_mem_ADDR/WDATA/BMASK/WREN   memory beat, muxed from current owner
//   o_mem_VALID / i_mem_READY     memory beat handshake
//   i_mem_RDATA                   memory read data
//   o_grant                       one-hot owner (bit0 port 0, bit1 port 1)
//
// States:
//   ARB_IDLE | no owner, arbitrate between pending requests
//   ARB_P0   | port 0 owns memory until its last beat handshakes
//   ARB_P1   | port 1 owns memory until its last beat handshakes
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TOTAL_ADDR_W  = 18,
    parameter int OFFSET_ADDR_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic [TOTAL_ADDR_W-1:0] i_p0_ADDR,
    input  logic [31:0]             i_p0_WDATA,
    input  logic [3:0]              i_p0_BMASK,
    input  logic                    i_p0_WREN,
    input  logic                    i_p0_VALID,
    output logic                    o_p0_READY,
    output logic [31:0]             o_p0_RDATA,

    input  logic [TOTAL_ADDR_W-1:0] i_p1_ADDR,
    input  logic [31:0]             i_p1_WDATA,
    input  logic [3:0]              i_p1_BMASK,
    input  logic                    i_p1_WREN,
    input  logic                    i_p1_VALID,
    output logic                    o_p1_READY,
    output logic [31:0]             o_p1_RDATA,

    output logic [TOTAL_ADDR_W-1:0] o_mem_ADDR,
    output logic [31:0]             o_mem_WDATA,
    output logic [3:0]              o_mem_BMASK,
    output logic                    o_mem_WREN,
    output logic                    o_mem_VALID,
    input  logic [31:0]             i_mem_RDATA,
    input  logic                    i_mem_READY,

    output logic [1:0]              o_grant
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_P0   = 2'd1,
        ARB_P1   = 2'd2
    } arb_state_t;

    localparam logic [OFFSET_ADDR_W-1:0] BEAT_LAST = '1;
    localparam logic [OFFSET_ADDR_W-1:0] BEAT_ONE  = OFFSET_ADDR_W'(1);

    arb_state_t                 state_q, state_d;
    logic [OFFSET_ADDR_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                       last_q, last_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ARB_IDLE;
            beat_cnt_q <= '0;
            last_q     <= 1'b1;   // port 0 wins the first tie
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
        end
    end

    // Read data is broadcast; it only matters while the port sees READY.
    assign o_p0_RDATA = i_mem_RDATA;
    assign o_p1_RDATA = i_mem_RDATA;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        last_d      = last_q;
        o_mem_ADDR  = '0;
        o_mem_WDATA = '0;
        o_mem_BMASK = '0;
        o_mem_WREN  = 1'b0;
        o_mem_VALID = 1'b0;
        o_p0_READY  = 1'b0;
        o_p1_READY  = 1'b0;
        o_grant     = 2'b00;

        case (state_q)
            ARB_IDLE: begin
                // Counter is held at zero here so every grant starts at beat 0.
                beat_cnt_d = '0;
                if (i_p0_VALID && i_p1_VALID) begin
`ifdef MEM_ARB_DCACHE_PRIO_EN
                    state_d = ARB_P1;
`else
                    state_d = last_q ? ARB_P0 : ARB_P1;
`endif
                end else if (i_p0_VALID) begin
                    state_d = ARB_P0;
                end else if (i_p1_VALID) begin
                    state_d = ARB_P1;
                end
            end

            ARB_P0: begin
                o_grant     = 2'b01;
                o_mem_ADDR  = i_p0_ADDR;
                o_mem_WDATA = i_p0_WDATA;
                o_mem_BMASK = i_p0_BMASK;
                o_mem_WREN  = i_p0_WREN;
                // A VALID gap holds the grant with the count frozen.
                o_mem_VALID = i_p0_VALID;
                o_p0_READY  = i_mem_READY & i_p0_VALID;
                if (i_p0_VALID && i_mem_READY) begin
                    beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d = ARB_IDLE;
                        last_d  = 1'b0;
                    end
                end
            end

            ARB_P1: begin
                o_grant     = 2'b10;
                o_mem_ADDR  = i_p1_ADDR;
                o_mem_WDATA = i_p1_WDATA;
                o_mem_BMASK = i_p1_BMASK;
                o_mem_WREN  = i_p1_WREN;
                o_mem_VALID = i_p1_VALID;
                o_p1_READY  = i_mem_READY & i_p1_VALID;
                if (i_p1_VALID && i_mem_READY) begin
                    beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d = ARB_IDLE;
                        last_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 18;
    localparam int OW = 4;
    localparam int BL = 16;

    localparam logic [AW-1:0] P0_BASE = 18'h01000;
    localparam logic [AW-1:0] P1_BASE = 18'h20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [31:0]   p0_wdata = '0, p1_wdata = '0;
    logic [3:0]    p0_bmask = '0, p1_bmask = '0;
    logic          p0_wren = 1'b0, p1_wren = 1'b0;
    logic          p0_valid = 1'b0, p1_valid = 1'b0;
    logic          p0_ready, p1_ready;
    logic [31:0]   p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_bmask;
    logic          mem_wren, mem_valid;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TOTAL_ADDR_W(AW), .OFFSET_ADDR_W(OW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_ADDR(p0_addr), .i_p0_WDATA(p0_wdata), .i_p0_BMASK(p0_bmask),
        .i_p0_WREN(p0_wren), .i_p0_VALID(p0_valid),
        .o_p0_READY(p0_ready), .o_p0_RDATA(p0_rdata),
        .i_p1_ADDR(p1_addr), .i_p1_WDATA(p1_wdata), .i_p1_BMASK(p1_bmask),
        .i_p1_WREN(p1_wren), .i_p1_VALID(p1_valid),
        .o_p1_READY(p1_ready), .o_p1_RDATA(p1_rdata),
        .o_mem_ADDR(mem_addr), .o_mem_WDATA(mem_wdata), .o_mem_BMASK(mem_bmask),
        .o_mem_WREN(mem_wren), .o_mem_VALID(mem_valid),
        .i_mem_RDATA(mem_rdata), .i_mem_READY(mem_ready),
        .o_grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        p0_wren = 1'b0;  p1_wren = 1'b0;
        p0_addr = P0_BASE; p1_addr = P1_BASE;
        p0_bmask = 4'hF; p1_bmask = 4'hF;
        mem_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_valid = 1'b1; p1_valid = 1'b1;
        p0_addr = P0_BASE; p1_addr = P1_BASE;
        p0_wdata = 32'h1234_5678; p0_bmask = 4'hF; p0_wren = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({mem_valid, mem_wren, mem_addr, mem_wdata, mem_bmask, p0_ready, p1_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b wren=%b addr=%h wdata=%h bmask=%h r0=%b r1=%b want all 0",
                     mem_valid, mem_wren, mem_addr, mem_wdata, mem_bmask, p0_ready, p1_ready);
        end
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL reset_grant got=%b want=00", grant);
        end
        p0_wren = 1'b0;
    endtask

    task automatic test_single();
        logic [AW-1:0] ea;
        do_reset();
        p0_valid = 1'b1;
        tick();
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            ea = P0_BASE + AW'(4 * i);
            total++;
            if (grant !== 2'b01) begin
                bad++;
                $display("FAIL single_grant beat=%0d got=%b want=01", i, grant);
            end
            total++;
            if (p0_ready !== 1'b1 || mem_valid !== 1'b1) begin
                bad++;
                $display("FAIL single_ready beat=%0d got r0=%b mv=%b want 1,1", i, p0_ready, mem_valid);
            end
            total++;
            if (mem_addr !== ea) begin
                bad++;
                $display("FAIL single_addr beat=%0d got=%h want=%h", i, mem_addr, ea);
            end
            tick();
            p0_addr = P0_BASE + AW'(4 * (i + 1));
        end
        p0_valid = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 2'b00 || mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release got grant=%b mv=%b want 00,0", grant, mem_valid);
        end
    endtask

    task automatic test_tie();
        logic [1:0] first;
`ifdef MEM_ARB_DCACHE_PRIO_EN
        first = 2'b10;
`else
        first = 2'b01;
`endif
        do_reset();
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        tick();
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            total++;
            if (grant !== first || {p1_ready, p0_ready} !== first) begin
                bad++;
                $display("FAIL tie_first beat=%0d got grant=%b ready=%b%b want %b", i, grant, p1_ready, p0_ready, first);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (grant !== 2'b00 || p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
            bad++;
            $display("FAIL tie_idle got grant=%b r0=%b r1=%b want 00,0,0", grant, p0_ready, p1_ready);
        end
        tick();
        @(negedge clk);
        total++;
        if (grant !== 2'b10 || p1_ready !== 1'b1 || mem_addr !== P1_BASE) begin
            bad++;
            $display("FAIL tie_second got grant=%b r1=%b addr=%h want 10,1,%h", grant, p1_ready, mem_addr, P1_BASE);
        end
    endtask

    task automatic test_lock();
        logic [AW-1:0] ea;
        do_reset();
        p0_valid = 1'b1;
        tick();
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            ea = P0_BASE + AW'(4 * i);
            total++;
            if (p1_ready !== 1'b0 || p0_ready !== 1'b1 || mem_addr !== ea) begin
                bad++;
                $display("FAIL lock_beat beat=%0d got r0=%b r1=%b addr=%h want 1,0,%h", i, p0_ready, p1_ready, mem_addr, ea);
            end
            tick();
            p0_addr = P0_BASE + AW'(4 * (i + 1));
            if (i == 4) p1_valid = 1'b1;
        end
        p0_valid = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 2'b00 || p1_ready !== 1'b0) begin
            bad++;
            $display("FAIL lock_idle got grant=%b r1=%b want 00,0", grant, p1_ready);
        end
        tick();
        @(negedge clk);
        total++;
        if (grant !== 2'b10 || p1_ready !== 1'b1 || mem_addr !== P1_BASE) begin
            bad++;
            $display("FAIL lock_p1_grant got grant=%b r1=%b addr=%h want 10,1,%h", grant, p1_ready, mem_addr, P1_BASE);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        int beats;
        do_reset();
        p0_valid = 1'b1;
        p0_wren  = 1'b1;
        p0_bmask = 4'h3;
        p0_wdata = 32'hA500_0000;
        mem_ready = 1'b0;
        tick();
        beats = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (grant !== 2'b01) break;
            total++;
            if (mem_wren !== 1'b1 || mem_bmask !== 4'h3 || mem_wdata !== (32'hA500_0000 + 32'(beats))) begin
                bad++;
                $display("FAIL ws_pass cyc=%0d got wren=%b bmask=%h wdata=%h want 1,3,%h",
                         cyc, mem_wren, mem_bmask, mem_wdata, 32'hA500_0000 + 32'(beats));
            end
            total++;
            if (p0_ready !== mem_ready) begin
                bad++;
                $display("FAIL ws_ready cyc=%0d got=%b want=%b", cyc, p0_ready, mem_ready);
            end
            if (p0_ready === 1'b1) beats++;
            tick();
            p0_wdata  = 32'hA500_0000 + 32'(beats);
            p0_addr   = P0_BASE + AW'(4 * beats);
            mem_ready = ~mem_ready;
        end
        total++;
        if (cyc !== 32 || beats !== 16) begin
            bad++;
            $display("FAIL ws_length got cycles=%0d beats=%0d want 32,16", cyc, beats);
        end
        p0_wren = 1'b0;
    endtask

    task automatic test_gap();
        int cyc;
        int beats;
        int gap;
        do_reset();
        mem_rdata = 32'hDEAD_BEEF;
        p0_valid = 1'b1;
        tick();
        beats = 0;
        gap = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (grant !== 2'b01) break;
            if (cyc == 0) begin
                total++;
                if (p0_rdata !== 32'hDEAD_BEEF || p1_rdata !== 32'hDEAD_BEEF) begin
                    bad++;
                    $display("FAIL gap_rdata got p0=%h p1=%h want deadbeef", p0_rdata, p1_rdata);
                end
            end
            total++;
            if (p0_valid) begin
                if (p0_ready !== 1'b1 || mem_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL gap_active cyc=%0d got r0=%b mv=%b want 1,1", cyc, p0_ready, mem_valid);
                end
            end else begin
                if (p0_ready !== 1'b0 || mem_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL gap_hold cyc=%0d got r0=%b mv=%b want 0,0", cyc, p0_ready, mem_valid);
                end
            end
            if (p0_ready === 1'b1) beats++;
            tick();
            if (beats == 8 && gap < 3) begin
                p0_valid = 1'b0;
                gap++;
            end else begin
                p0_valid = 1'b1;
            end
        end
        total++;
        if (cyc !== 19 || beats !== 16) begin
            bad++;
            $display("FAIL gap_length got cycles=%0d beats=%0d want 19,16", cyc, beats);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int beats;
        do_reset();
        p1_valid = 1'b1;
        tick();
        repeat (10) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if (mem_valid !== 1'b0 || grant !== 2'b00 || p1_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got mv=%b grant=%b r1=%b want 0,00,0", mem_valid, grant, p1_ready);
        end
        p1_valid = 1'b0;
        p0_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_still_idle got=%b want=00", grant);
        end
        tick();
        beats = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (grant !== 2'b01) break;
            if (p0_ready === 1'b1) beats++;
            tick();
        end
        total++;
        if (cyc !== 16 || beats !== 16) begin
            bad++;
            $display("FAIL rstmid_p0_burst got cycles=%0d beats=%0d want 16,16", cyc, beats);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_lock();
        test_wait_states();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
